// File: rtl/wb_gpio_poller.sv
// wb_gpio_poller: Wishbone master that initialises a GPIO slave, then polls its input word
// and raises sticky per-bit change flags, with timeout and bus-error tracking.
module wb_gpio_poller #(
  parameter int              SIZE        = 32,
  parameter logic [31:0]     BASE        = 32'h0,
  parameter logic [SIZE-1:0] DIR_INIT    = '0,
  parameter logic [SIZE-1:0] OUT_INIT    = '0,
  parameter int              POLL_PERIOD = 1000,
  parameter int              TIMEOUT     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            m_cyc,
  output logic            m_stb,
  output logic            m_we,
  output logic [31:0]     m_adr,
  output logic [31:0]     m_dat_o,
  output logic [3:0]      m_sel,
  input  logic [31:0]     m_dat_i,
  input  logic            m_ack,
  input  logic            m_stall,
  input  logic            m_err,
  input  logic            poll_now,
  input  logic [SIZE-1:0] clr,
  output logic [SIZE-1:0] gpio_in,
  output logic [SIZE-1:0] pending,
  output logic            irq,
  output logic            init_done,
  output logic            bus_err
);
  localparam int CW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {INIT_OUT, INIT_DIR, FIRST_RD, WAIT, POLL} state_t;
  state_t          state_q, state_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            poll_q, poll_d, irq_q, init_q, init_d, berr_q, berr_d;
  logic [SIZE-1:0] gpio_q, gpio_d, pend_q, pend_d, rd;
  logic            ack_ok, done, rd_st, issue, unused_ok;
  assign rd        = m_dat_i[SIZE-1:0];
  assign unused_ok = ^m_dat_i;
  // m_err takes priority over m_ack; a timeout completes the cycle as a failure
  assign ack_ok = m_ack && !m_err;
  assign done   = cyc_q && (m_ack || m_err || tmo_q == TW'(TIMEOUT - 1));
  assign rd_st  = state_q == FIRST_RD || state_q == POLL;
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q | poll_now;
    gpio_d  = gpio_q;
    pend_d  = pend_q & ~clr;
    init_d  = init_q;
    berr_d  = berr_q;
    issue   = 1'b0;
    if (cyc_q) begin
      tmo_d = tmo_q + 1'b1;
      if (stb_q && !m_stall) stb_d = 1'b0;
      if (done) begin
        cyc_d  = 1'b0;
        stb_d  = 1'b0;
        berr_d = berr_q | ~ack_ok;
        if (rd_st) begin
          gpio_d  = ack_ok ? rd : gpio_q;
          pend_d  = pend_d | ((ack_ok && state_q == POLL) ? rd ^ gpio_q : '0);
          init_d  = init_q | (state_q == FIRST_RD);
          cnt_d   = CW'(POLL_PERIOD - 1);
          poll_d  = 1'b0;
          state_d = (poll_q | poll_now) ? POLL : WAIT;
        end else state_d = state_q == INIT_OUT ? INIT_DIR : FIRST_RD;
      end
    end else if (state_q == WAIT) begin
      poll_d = 1'b0;
      cnt_d  = cnt_q - 1'b1;
      if (poll_now || cnt_q == '0) begin
        state_d = POLL;
        issue   = 1'b1;
      end
    end else issue = 1'b1;
    if (issue) begin
      cyc_d = 1'b1;
      stb_d = 1'b1;
      tmo_d = '0;
      we_d  = state_d == INIT_OUT || state_d == INIT_DIR;
      adr_d = BASE + (state_d == INIT_OUT ? 32'd4 : state_d == INIT_DIR ? 32'd8 : 32'd0);
      dat_d = state_d == INIT_OUT ? 32'(OUT_INIT) : state_d == INIT_DIR ? 32'(DIR_INIT) : 32'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INIT_OUT;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      poll_q  <= 1'b0;
      gpio_q  <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      init_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      gpio_q  <= gpio_d;
      pend_q  <= pend_d;
      irq_q   <= |pend_q;
      init_q  <= init_d;
      berr_q  <= berr_d;
    end
  assign m_cyc     = cyc_q;
  assign m_stb     = stb_q;
  assign m_we      = we_q;
  assign m_adr     = adr_q;
  assign m_dat_o   = dat_q;
  assign m_sel     = 4'hF;
  assign gpio_in   = gpio_q;
  assign pending   = pend_q;
  assign irq       = irq_q;
  assign init_done = init_q;
  assign bus_err   = berr_q;
endmodule

// File: tb/tb_wb_gpio_poller.sv
// tb_wb_gpio_poller: scripted Wishbone slave plus a bit-level model of the GPIO change flags.
module tb_wb_gpio_poller;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] DIRV = 32'h0000_FF00;
  localparam logic [31:0] OUTV = 32'h0000_00A5;
  localparam int          PER  = 10;
  localparam int          TMO  = 16;
  typedef struct {
    logic        we;
    logic [31:0] adr, dat, rdata;
    int          t_stb, t_end, n_stb, cyc_len, mode, stall;
  } txn_t;
  logic        clk, rst_n, m_cyc, m_stb, m_we, m_ack, m_stall, m_err, poll_now, irq, init_done, bus_err;
  logic [31:0] m_adr, m_dat_o, m_dat_i, clr, gpio_in, pending;
  logic [3:0]  m_sel;
  logic [31:0] gpio_val, exp_gpio, exp_pend;
  logic        exp_berr;
  int          next_mode, next_stall, cyc_n, checks, failures;
  txn_t        q[$];
  wb_gpio_poller #(.SIZE(32), .BASE(BASE), .DIR_INIT(DIRV), .OUT_INIT(OUTV),
                   .POLL_PERIOD(PER), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_o(m_dat_o), .m_sel(m_sel), .m_dat_i(m_dat_i), .m_ack(m_ack), .m_stall(m_stall),
    .m_err(m_err), .poll_now(poll_now), .clr(clr), .gpio_in(gpio_in), .pending(pending),
    .irq(irq), .init_done(init_done), .bus_err(bus_err));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // mode: 0 ack, 1 err, 2 silent, 3 ack+err; response comes the cycle after stb is accepted
  task automatic serve();
    txn_t t = '{default: 0};
    int   k = 0;
    t.we    = m_we;
    t.adr   = m_adr;
    t.dat   = m_dat_o;
    t.mode  = next_mode;
    t.stall = next_stall;
    t.t_stb = cyc_n;
    while (m_cyc === 1'b1) begin
      if (m_stb === 1'b1) t.n_stb++;
      m_stall = m_stb && k < t.stall;
      m_ack   = k == t.stall + 1 && (t.mode == 0 || t.mode == 3);
      m_err   = k == t.stall + 1 && (t.mode == 1 || t.mode == 3);
      if (m_ack) t.rdata = gpio_val;
      m_dat_i = m_ack ? gpio_val : $urandom;
      k++;
      @(posedge clk);
      #1;
    end
    t.cyc_len = k;
    t.t_end   = cyc_n;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_stall   = 1'b0;
    q.push_back(t);
  endtask
  initial begin
    m_ack = 1'b0; m_err = 1'b0; m_stall = 1'b0; m_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_cyc === 1'b1 && m_stb === 1'b1) serve();
    end
  end
  task automatic wait_txn(output txn_t t);
    int n = 0;
    while (q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("txn_arrived", q.size() != 0, 1);
    t = '{default: 0};
    if (q.size() != 0) t = q.pop_front();
  endtask
  // reference: a good read flags every flipped bit (except the first read) and becomes the new sample
  task automatic expect_read(input txn_t t, input bit first, input string tag);
    chk({tag, "_rd_we"}, t.we, 0);
    chk({tag, "_rd_adr"}, t.adr, BASE);
    if (t.mode == 0) begin
      if (!first) exp_pend = exp_pend | (t.rdata ^ exp_gpio);
      exp_gpio = t.rdata;
    end else exp_berr = 1'b1;
    chk({tag, "_gpio_in"}, gpio_in, exp_gpio);
    chk({tag, "_pending"}, pending, exp_pend);
    chk({tag, "_bus_err"}, bus_err, exp_berr);
  endtask
  task automatic wait_until_cyc(input bit ack_phase);
    int n = 0;
    while (!(m_cyc === 1'b1 && (!ack_phase || m_stb === 1'b0)) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("cyc_phase_seen", n < 60, 1);
  endtask
  initial begin
    txn_t        t, prev;
    int          rel;
    logic [31:0] c;
    checks = 0; failures = 0;
    rst_n = 1'b0; poll_now = 1'b0; clr = '0;
    gpio_val = '0; next_mode = 0; next_stall = 0;
    exp_gpio = '0; exp_pend = '0; exp_berr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc_stb_we", {m_cyc, m_stb, m_we}, 0);
    chk("rst_adr", m_adr, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_flags", {irq, init_done, bus_err}, 0);
    chk("rst_gpio_pend", gpio_in | pending, 0);
    rel = cyc_n;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_issue", {m_cyc, m_stb}, 2'b11);
    chk("sel", m_sel, 4'hF);
    wait_txn(t);
    chk("init_out_we", t.we, 1);
    chk("init_out_adr", t.adr, BASE + 4);
    chk("init_out_dat", t.dat, OUTV);
    chk("init_out_start", t.t_stb, rel + 1);
    chk("init_out_shape", {t.n_stb[7:0], t.cyc_len[7:0]}, 16'h0102);
    chk("init_done_early", init_done, 0);
    prev = t;
    wait_txn(t);
    chk("init_dir_we", t.we, 1);
    chk("init_dir_adr", t.adr, BASE + 8);
    chk("init_dir_dat", t.dat, DIRV);
    chk("init_dir_start", t.t_stb, prev.t_end + 1);
    wait_txn(t);
    expect_read(t, 1, "first_rd");
    chk("init_done", init_done, 1);
    prev = t;
    gpio_val = 32'h0000_0005;
    wait_txn(t);
    chk("poll_period", t.t_stb - prev.t_end, PER);
    expect_read(t, 0, "poll_5");
    chk("pend_5", pending, 32'h5);
    chk("irq_lag", irq, 0);
    @(negedge clk);
    chk("irq_set", irq, 1);
    clr = 32'h1;
    @(negedge clk);
    clr = '0;
    exp_pend = exp_pend & ~32'h1;
    chk("clr_bit0", pending, 32'h4);
    gpio_val = 32'h0000_0001;
    wait_until_cyc(1);
    clr = 32'h4;
    @(negedge clk);
    clr = '0;
    exp_pend = exp_pend & ~32'h4;
    wait_txn(t);
    expect_read(t, 0, "set_beats_clr");
    chk("pend_bit2", pending[2], 1);
    prev = t;
    gpio_val = $urandom;
    repeat (3) @(negedge clk);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    wait_txn(t);
    chk("poll_now_wait", t.t_stb, prev.t_end + 4);
    expect_read(t, 0, "poll_now");
    prev = t;
    wait_txn(t);
    chk("period_after_now", t.t_stb - prev.t_end, PER);
    expect_read(t, 0, "after_now");
    gpio_val = $urandom;
    wait_until_cyc(0);
    poll_now = 1'b1;
    repeat (2) @(negedge clk);
    poll_now = 1'b0;
    wait_txn(t);
    expect_read(t, 0, "latch_src");
    prev = t;
    gpio_val = $urandom;
    wait_txn(t);
    chk("latched_poll", t.t_stb, prev.t_end + 1);
    expect_read(t, 0, "latched");
    prev = t;
    wait_txn(t);
    chk("merged_requests", t.t_stb - prev.t_end, PER);
    expect_read(t, 0, "merged");
    next_stall = 5;
    gpio_val = $urandom;
    wait_txn(t);
    next_stall = 0;
    chk("stall_stb_cycles", t.n_stb, 6);
    chk("stall_cyc_cycles", t.cyc_len, 7);
    expect_read(t, 0, "stall");
    next_mode = 2;
    gpio_val = exp_gpio ^ 32'h00F0_0F00;
    wait_txn(t);
    next_mode = 0;
    chk("timeout_len", t.cyc_len, TMO);
    expect_read(t, 0, "timeout");
    prev = t;
    wait_txn(t);
    chk("poll_after_tmo", t.t_stb - prev.t_end, PER);
    expect_read(t, 0, "after_tmo");
    next_stall = 8;
    wait_until_cyc(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc_stb", {m_cyc, m_stb}, 0);
    chk("midrst_state", {irq, init_done, bus_err}, 0);
    chk("midrst_regs", gpio_in | pending, 0);
    next_stall = 0;
    repeat (2) @(negedge clk);
    q.delete();
    exp_gpio = '0; exp_pend = '0; exp_berr = 1'b0;
    next_mode = 1;
    gpio_val = $urandom;
    rst_n = 1'b1;
    wait_txn(t);
    next_mode = 0;
    chk("rerun_init_adr", t.adr, BASE + 4);
    chk("err_init_berr", bus_err, 1);
    exp_berr = 1'b1;
    prev = t;
    wait_txn(t);
    chk("err_next_adr", t.adr, BASE + 8);
    chk("err_next_start", t.t_stb, prev.t_end + 1);
    wait_txn(t);
    expect_read(t, 1, "rerun_first");
    chk("rerun_init_done", init_done, 1);
    next_mode = 3;
    gpio_val = exp_gpio ^ 32'hFFFF_0000;
    wait_txn(t);
    next_mode = 0;
    expect_read(t, 0, "ack_err");
    for (int i = 0; i < 8; i++) begin
      gpio_val = $urandom;
      if ($urandom_range(1) == 1) begin
        c = $urandom;
        clr = c;
        @(negedge clk);
        clr = '0;
        exp_pend = exp_pend & ~c;
        chk("rand_clr", pending, exp_pend);
      end
      wait_txn(t);
      expect_read(t, 0, "rand");
      @(negedge clk);
      chk("rand_irq", irq, |exp_pend);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
